// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: masked multi-channel scan sequencer driving an SPI ADC master
module adc_scan_ctrl #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int PERIOD  = 1000,
    parameter int SETTLE  = 8,
    parameter int TIMEOUT = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              trig,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              err_clr,
    output logic              spi_start,
    input  logic              spi_cs_n,
    input  logic [15:0]       spi_data,
    output logic [CH_W-1:0]   ch_sel,
    output logic              smp_valid,
    output logic [CH_W-1:0]   smp_ch,
    output logic [15:0]       smp_data,
    output logic              scan_done,
    output logic              busy,
    output logic              timeout_err,
    output logic              overrun
);
    localparam int PW = $clog2(PERIOD);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_WAIT_LOW, S_WAIT_HIGH, S_STORE} state_t;

    state_t            state;
    logic [PW-1:0]     pcnt;
    logic [SW-1:0]     scnt;
    logic [TW-1:0]     tcnt;
    logic [NUM_CH-1:0] mask_r;
    logic [CH_W-1:0]   first_ch, nxt_ch;
    logic              nxt_any, tc, req;

    assign tc  = enable && pcnt == PW'(PERIOD - 1);
    assign req = trig || tc;

    always_comb begin
        first_ch = '0;
        nxt_ch   = '0;
        nxt_any  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) first_ch = CH_W'(i);
            if (mask_r[i] && CH_W'(i) > ch_sel) begin
                nxt_ch  = CH_W'(i);
                nxt_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pcnt        <= '0;
            scnt        <= '0;
            tcnt        <= '0;
            mask_r      <= '0;
            spi_start   <= 1'b0;
            ch_sel      <= '0;
            smp_valid   <= 1'b0;
            smp_ch      <= '0;
            smp_data    <= '0;
            scan_done   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            smp_valid <= 1'b0;
            scan_done <= 1'b0;
            pcnt      <= (!enable || tc) ? '0 : pcnt + 1'b1;
            if (err_clr) begin
                timeout_err <= 1'b0;
                overrun     <= 1'b0;
            end
            if (tc && state != S_IDLE) overrun <= 1'b1;
            case (state)
                S_IDLE: if (req) begin
                    mask_r <= ch_mask;
                    if (ch_mask == '0) scan_done <= 1'b1;
                    else begin
                        ch_sel <= first_ch;
                        scnt   <= '0;
                        state  <= S_SETTLE;
                        busy   <= 1'b1;
                    end
                end
                S_SETTLE: if (scnt == SW'(SETTLE - 1)) begin
                    state     <= S_START;
                    spi_start <= 1'b1;
                    tcnt      <= '0;
                end else scnt <= scnt + 1'b1;
                S_START: begin
                    tcnt  <= tcnt + 1'b1;
                    state <= S_WAIT_LOW;
                end
                // tcnt counts cycles since spi_start, so the abort lands exactly TIMEOUT cycles after it
                S_WAIT_LOW, S_WAIT_HIGH: if (tcnt == TW'(TIMEOUT - 1)) begin
                    timeout_err <= 1'b1;
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                    if (state == S_WAIT_LOW && !spi_cs_n) state <= S_WAIT_HIGH;
                    else if (state == S_WAIT_HIGH && spi_cs_n) state <= S_STORE;
                end
                S_STORE: begin
                    smp_data  <= spi_data;
                    smp_ch    <= ch_sel;
                    smp_valid <= 1'b1;
                    if (nxt_any) begin
                        ch_sel <= nxt_ch;
                        scnt   <= '0;
                        state  <= S_SETTLE;
                    end else begin
                        scan_done <= 1'b1;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: table-driven scans with a result scoreboard and an SPI master model
module tb_adc_scan_ctrl;
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 64;
    localparam int PERIOD  = 50;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] base;
        int          n;
        logic [7:0]  chs;
    } vec_t;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, enable, trig, err_clr;
    logic [3:0]  ch_mask;
    logic        spi_start, smp_valid, scan_done, busy, timeout_err, overrun;
    logic        spi_cs_n = 1'b1;
    logic [15:0] spi_data = '0;
    logic [1:0]  ch_sel, smp_ch;
    logic [15:0] smp_data;

    int total = 0, bad = 0;
    exp_t sbq[$];
    exp_t e;
    vec_t tbl[5];

    int cyc = 0, valid_cnt = 0, done_cnt = 0, done_alone = 0, start_cnt = 0, busy_cnt = 0;
    int start_cyc = 0, to_cyc = 0, busyfall_cyc = 0, since = 0;
    logic [3:0] visited = '0;
    logic [1:0] prev_ch = '0;
    logic prev_busy = 1'b0, prev_to = 1'b0;

    logic        spi_dead = 1'b0;
    logic [15:0] spi_base = '0;
    int          xfer_len = 40;
    int          xfer = 0;

    always #5 clk = ~clk;

    adc_scan_ctrl #(.NUM_CH(4), .CH_W(2), .PERIOD(PERIOD), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .trig(trig), .ch_mask(ch_mask),
        .err_clr(err_clr), .spi_start(spi_start), .spi_cs_n(spi_cs_n), .spi_data(spi_data),
        .ch_sel(ch_sel), .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_data(smp_data),
        .scan_done(scan_done), .busy(busy), .timeout_err(timeout_err), .overrun(overrun)
    );

    always @(posedge clk) begin
        if (!rst_n) begin
            xfer     <= 0;
            spi_cs_n <= 1'b1;
        end else if (spi_start && !spi_dead) begin
            xfer     <= xfer_len;
            spi_cs_n <= 1'b0;
            spi_data <= spi_base + 16'(ch_sel);
        end else if (xfer == 1) begin
            xfer     <= 0;
            spi_cs_n <= 1'b1;
        end else if (xfer > 1) xfer <= xfer - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (ch_sel != prev_ch || (busy && !prev_busy)) since = 0;
        else since++;
        if (busy && !prev_busy) visited = '0;
        if (busy) begin
            busy_cnt++;
            visited[ch_sel] = 1'b1;
        end
        if (smp_valid) begin
            valid_cnt++;
            if (sbq.size() == 0) chk("sb_underflow", sbq.size(), 1);
            else begin
                e = sbq.pop_front();
                chk("smp_ch", smp_ch, e.ch);
                chk("smp_data", smp_data, e.data);
                chk("done_with_last", scan_done, e.last);
            end
        end
        if (scan_done) begin
            done_cnt++;
            if (!smp_valid) done_alone++;
        end
        if (spi_start) begin
            start_cnt++;
            start_cyc = cyc;
            chk("settle_gap", since, SETTLE);
        end
        if (timeout_err && !prev_to) to_cyc = cyc;
        if (!busy && prev_busy) busyfall_cyc = cyc;
        prev_ch   = ch_sel;
        prev_busy = busy;
        prev_to   = timeout_err;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        step();
        trig = 1'b0;
    endtask

    task automatic push_scan(input logic [3:0] mask, input logic [15:0] base, input int n, input logic [7:0] chs);
        for (int k = 0; k < n; k++)
            sbq.push_back('{chs[2*k +: 2], base + 16'(chs[2*k +: 2]), k == n - 1});
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int k = 0; k < budget && done_cnt == d0; k++) step();
        chk("scan_done_seen", done_cnt - d0, 1);
    endtask

    task automatic chk_zero();
        chk("rst_spi_start", spi_start, 0);
        chk("rst_ch_sel", ch_sel, 0);
        chk("rst_smp_valid", smp_valid, 0);
        chk("rst_smp_ch", smp_ch, 0);
        chk("rst_smp_data", smp_data, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_overrun", overrun, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, d0, da0, s0, b0;
        rst_n = 1'b0; enable = 1'b0; trig = 1'b0; err_clr = 1'b0; ch_mask = '0;
        tbl[0] = '{4'b1111, 16'hA000, 4, 8'b11_10_01_00};
        tbl[1] = '{4'b1010, 16'hB000, 2, 8'b00_00_11_01};
        tbl[2] = '{4'b0100, 16'hC000, 1, 8'b00_00_00_10};
        tbl[3] = '{4'b1001, 16'hD000, 2, 8'b00_00_11_00};
        tbl[4] = '{4'b0000, 16'h0000, 0, 8'b00_00_00_00};
        repeat (3) step();
        chk_zero();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            spi_base = tbl[i].base;
            ch_mask  = tbl[i].mask;
            push_scan(tbl[i].mask, tbl[i].base, tbl[i].n, tbl[i].chs);
            v0 = valid_cnt; d0 = done_cnt; da0 = done_alone; s0 = start_cnt; b0 = busy_cnt;
            pulse_trig();
            ch_mask = ~tbl[i].mask;
            wait_done(d0, 1500);
            step(); step();
            chk("vec_valid_cnt", valid_cnt - v0, tbl[i].n);
            chk("vec_start_cnt", start_cnt - s0, tbl[i].n);
            chk("vec_done_alone", done_alone - da0, tbl[i].n == 0);
            chk("vec_sb_empty", sbq.size(), 0);
            chk("vec_busy_end", busy, 0);
            if (tbl[i].n == 0) chk("zero_busy_cycles", busy_cnt - b0, 0);
            else chk("vec_visited", visited, tbl[i].mask);
        end

        spi_dead = 1'b1;
        ch_mask  = 4'b0100;
        v0 = valid_cnt; d0 = done_cnt; s0 = start_cnt;
        pulse_trig();
        for (int k = 0; k < 300 && busy; k++) step();
        chk("to_idle", busy, 0);
        chk("to_err", timeout_err, 1);
        chk("to_latency", to_cyc - start_cyc, TIMEOUT);
        chk("to_busy_fall", busyfall_cyc - start_cyc, TIMEOUT);
        chk("to_no_valid", valid_cnt - v0, 0);
        chk("to_no_done", done_cnt - d0, 0);
        chk("to_one_start", start_cnt - s0, 1);
        spi_dead = 1'b0;

        ch_mask  = 4'b1111;
        spi_base = 16'hE000;
        push_scan(4'b0001, 16'hE000, 1, 8'b00);
        sbq[$].last = 1'b0;
        v0 = valid_cnt;
        pulse_trig();
        for (int k = 0; k < 300 && valid_cnt == v0; k++) step();
        for (int k = 0; k < 100 && spi_cs_n; k++) step();
        chk("rm_in_xfer", spi_cs_n, 0);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk_zero();
        rst_n = 1'b1;
        step(); step();
        chk("rm_valid_cnt", valid_cnt - v0, 1);
        chk("rm_sb_empty", sbq.size(), 0);

        spi_base = 16'hF000;
        push_scan(4'b1111, 16'hF000, 4, 8'b11_10_01_00);
        v0 = valid_cnt; d0 = done_cnt;
        pulse_trig();
        wait_done(d0, 1500);
        step();
        chk("post_rst_valid_cnt", valid_cnt - v0, 4);
        chk("post_rst_sb_empty", sbq.size(), 0);

        ch_mask  = 4'b0011;
        spi_base = 16'h1000;
        xfer_len = 40;
        push_scan(4'b0011, 16'h1000, 2, 8'b01_00);
        d0 = done_cnt;
        enable = 1'b1;
        for (int k = 0; k < 300 && !overrun; k++) step();
        chk("ovr_set", overrun, 1);
        enable = 1'b0;
        wait_done(d0, 300);
        step();
        chk("ovr_sb_empty", sbq.size(), 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ovr_cleared", overrun, 0);
        xfer_len = 10;
        spi_base = 16'h2000;
        push_scan(4'b0011, 16'h2000, 2, 8'b01_00);
        v0 = valid_cnt; d0 = done_cnt;
        enable = 1'b1;
        wait_done(d0, 300);
        enable = 1'b0;
        repeat (3) step();
        chk("per_valid_cnt", valid_cnt - v0, 2);
        chk("per_sb_empty", sbq.size(), 0);
        chk("per_no_overrun", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
